// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load results onto the register file
// write port, ALU first, with an in-order squashable load buffer.
module writeback_arbiter #(
   parameter int DATA_W     = 16,
   parameter int REG_AW     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clock,
   input  logic                           rst,
   input  logic                           alu_valid,
   input  logic [REG_AW-1:0]              alu_dest,
   input  logic [DATA_W-1:0]              alu_data,
   input  logic                           mem_valid,
   input  logic [REG_AW-1:0]              mem_dest,
   input  logic [DATA_W-1:0]              mem_data,
   output logic                           mem_ready,
   output logic                           WE,
   output logic [REG_AW-1:0]              WrReg,
   output logic [DATA_W-1:0]              InData,
   output logic                           pc_write,
   output logic [15:0]                    pending_mask,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [REG_AW-1:0]     destQ [FIFO_DEPTH];
   logic [DATA_W-1:0]     dataQ [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] liveQ;
   logic [PTR_W-1:0]      rdPtr;
   logic [PTR_W-1:0]      wrPtr;
   logic [CNT_W-1:0]      count;

   logic              memReady;
   logic              accept;
   logic              push;
   logic              pop;
   logic              pushLive;
   logic              nextWe;
   logic [REG_AW-1:0] nextReg;
   logic [DATA_W-1:0] nextData;

   assign memReady   = !rst && (count < FULL_CNT);
   assign accept     = mem_valid && memReady;
   assign mem_ready  = memReady;
   assign fifo_count = count;
   // A load colliding with a same-cycle ALU write is older, so it is dead on arrival
   assign pushLive   = !(alu_valid && (mem_dest == alu_dest));

   always_comb begin
      nextWe   = 1'b0;
      nextReg  = WrReg;
      nextData = InData;
      push     = 1'b0;
      pop      = 1'b0;
      if (alu_valid) begin
         nextWe   = 1'b1;
         nextReg  = alu_dest;
         nextData = alu_data;
         push     = accept;
      end else if (count != '0) begin
         pop  = 1'b1;
         push = accept;
         if (liveQ[rdPtr]) begin
            nextWe   = 1'b1;
            nextReg  = destQ[rdPtr];
            nextData = dataQ[rdPtr];
         end
      end else if (mem_valid) begin
         nextWe   = 1'b1;
         nextReg  = mem_dest;
         nextData = mem_data;
      end
   end

   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (liveQ[i]) pending_mask[destQ[i]] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         WE       <= 1'b0;
         WrReg    <= '0;
         InData   <= '0;
         pc_write <= 1'b0;
         rdPtr    <= '0;
         wrPtr    <= '0;
         count    <= '0;
         liveQ    <= '0;
      end else begin
         WE       <= nextWe;
         WrReg    <= nextReg;
         InData   <= nextData;
         pc_write <= nextWe && (nextReg == '1);
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_valid && (destQ[i] == alu_dest)) liveQ[i] <= 1'b0;
         end
         if (pop) begin
            liveQ[rdPtr] <= 1'b0;
            rdPtr        <= rdPtr + 1'b1;
         end
         if (push) begin
            liveQ[wrPtr] <= pushLive;
            wrPtr        <= wrPtr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!rst && push) begin
         destQ[wrPtr] <= mem_dest;
         dataQ[wrPtr] <= mem_data;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed steps plus random traffic
// checked against a queue-based reference model.
module tb_writeback_arbiter;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic [3:0]  alu_dest = '0;
   logic [15:0] alu_data = '0;
   logic        mem_valid = 1'b0;
   logic [3:0]  mem_dest = '0;
   logic [15:0] mem_data = '0;
   logic        mem_ready;
   logic        WE;
   logic [3:0]  WrReg;
   logic [15:0] InData;
   logic        pc_write;
   logic [15:0] pending_mask;
   logic [2:0]  fifo_count;

   writeback_arbiter #(.DATA_W(16), .REG_AW(4), .FIFO_DEPTH(DEPTH)) dut (
      .clock(clock), .rst(rst),
      .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data),
      .mem_ready(mem_ready), .WE(WE), .WrReg(WrReg), .InData(InData),
      .pc_write(pc_write), .pending_mask(pending_mask),
      .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [3:0]  dest;
      logic [15:0] data;
      bit          live;
   } ent_t;

   ent_t        q[$];
   logic [3:0]  eReg = '0;
   logic [15:0] eData = '0;
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] modelMask();
      logic [15:0] m = '0;
      foreach (q[i]) if (q[i].live) m[q[i].dest] = 1'b1;
      return m;
   endfunction

   task automatic step(input logic av, input logic [3:0] ad,
                       input logic [15:0] adt, input logic mv,
                       input logic [3:0] md, input logic [15:0] mdt,
                       output logic acc);
      logic eWe;
      logic ready;
      ent_t e;
      alu_valid = av; alu_dest = ad; alu_data = adt;
      mem_valid = mv; mem_dest = md; mem_data = mdt;
      #1;
      ready = (q.size() < DEPTH);
      chk("mem_ready", 32'(mem_ready), 32'(ready));
      acc = mv && ready;
      eWe = 1'b0;
      if (av) begin
         eWe = 1'b1; eReg = ad; eData = adt;
         foreach (q[i]) if (q[i].dest == ad) q[i].live = 1'b0;
         if (acc) q.push_back('{md, mdt, md != ad});
      end else if (q.size() > 0) begin
         e = q.pop_front();
         if (e.live) begin
            eWe = 1'b1; eReg = e.dest; eData = e.data;
         end
         if (acc) q.push_back('{md, mdt, 1'b1});
      end else if (mv) begin
         eWe = 1'b1; eReg = md; eData = mdt;
      end
      @(posedge clock); #1;
      chk("WE", 32'(WE), 32'(eWe));
      chk("WrReg", 32'(WrReg), 32'(eReg));
      chk("InData", 32'(InData), 32'(eData));
      chk("pc_write", 32'(pc_write), 32'(eWe && eReg == 4'hF));
      chk("fifo_count", 32'(fifo_count), 32'(q.size()));
      chk("pending_mask", 32'(pending_mask), 32'(modelMask()));
   endtask

   task automatic idle();
      logic acc;
      step(1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, acc);
   endtask

   task automatic doReset(input int n);
      rst = 1'b1;
      alu_valid = 1'b0; mem_valid = 1'b0;
      #1;
      chk("rst_mem_ready", 32'(mem_ready), 32'd0);
      repeat (n) @(posedge clock);
      #1;
      q.delete();
      eReg = '0; eData = '0;
      chk("rst_WE", 32'(WE), 32'd0);
      chk("rst_WrReg", 32'(WrReg), 32'd0);
      chk("rst_InData", 32'(InData), 32'd0);
      chk("rst_pc_write", 32'(pc_write), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_mask", 32'(pending_mask), 32'd0);
      rst = 1'b0;
      #1;
      chk("rel_mem_ready", 32'(mem_ready), 32'd1);
   endtask

   initial begin
      logic acc;
      int k;
      doReset(2);

      // bypass into an empty buffer
      idle();
      step(1'b0, 4'h0, 16'h0, 1'b1, 4'd3, 16'h1234, acc);
      chk("bypass_data", 32'(InData), 32'h1234);
      idle();

      // contention: ALU busy while loads 4..7 queue up
      k = 0;
      for (int c = 0; c < 6; c++) begin
         step(1'b1, 4'd1, 16'(16'hA0 + c), k < 4, 4'(4 + k),
              16'(16'h400 + k), acc);
         if (acc) k++;
      end
      chk("contend_accepts", 32'(k), 32'd4);
      chk("contend_mask", 32'(pending_mask), 32'h00F0);
      for (int c = 0; c < 4; c++) begin
         idle();
         chk("drain_order", 32'(WrReg), 32'(4 + c));
      end
      idle();

      // squash of a queued load by a younger ALU write
      step(1'b1, 4'd2, 16'h0002, 1'b1, 4'd5, 16'h1111, acc);
      chk("squash_mask_set", 32'(pending_mask), 32'h0020);
      step(1'b1, 4'd5, 16'h2222, 1'b0, 4'd0, 16'h0, acc);
      chk("squash_mask_clr", 32'(pending_mask), 32'h0000);
      idle();
      chk("squash_pop_we", 32'(WE), 32'd0);
      idle();

      // same-cycle collision on R9
      step(1'b1, 4'd9, 16'h0009, 1'b1, 4'd9, 16'hFFFF, acc);
      chk("collide_acc", 32'(acc), 32'd1);
      idle();
      chk("collide_we", 32'(WE), 32'd0);
      idle();

      // PC write then reset with queued loads
      step(1'b1, 4'hF, 16'h0040, 1'b0, 4'd0, 16'h0, acc);
      chk("pc_pulse", 32'(pc_write), 32'd1);
      idle();
      chk("pc_pulse_end", 32'(pc_write), 32'd0);
      for (int c = 0; c < 3; c++)
         step(1'b1, 4'd1, 16'h0, 1'b1, 4'(8 + c), 16'(c), acc);
      chk("pre_rst_count", 32'(fifo_count), 32'd3);
      doReset(1);
      for (int c = 0; c < 4; c++) begin
         idle();
         chk("post_rst_we", 32'(WE), 32'd0);
      end

      // random traffic with clustered destinations
      for (int c = 0; c < 400; c++) begin
         logic [3:0] ad, md;
         ad = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
         md = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) doReset(1);
         else step($urandom_range(0, 99) < 55, ad, 16'($urandom),
                   $urandom_range(0, 99) < 60, md, 16'($urandom), acc);
      end
      repeat (6) idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
